// File: rtl/dds_spi_master.sv
`default_nettype none
// ============================================================================
// Module   : dds_spi_master
// Purpose  : Serialises a frequency-tuning or phase-shift word MSB-first onto
//            the DDS SPI bus (spi_clk / spi_data / freq_cs / phaseshift_cs).
//            The falling chip select at the end commits the word in the DDS.
// Revision : 1.0 - initial release
// ============================================================================
module dds_spi_master #(
    parameter int ACC_LENGTH   = 48,
    parameter int PHASE_LENGTH = 16,
    parameter int CLK_DIV      = 5
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  target,
    input  logic [ACC_LENGTH-1:0] data_in,
    output logic                  spi_clk,
    output logic                  spi_data,
    output logic                  freq_cs,
    output logic                  phaseshift_cs,
    output logic                  busy,
    output logic                  done
);

    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(ACC_LENGTH + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_SETUP = 3'd1;
    localparam logic [2:0] S_HIGH  = 3'd2;
    localparam logic [2:0] S_LOW   = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] N_FREQ   = BIT_W'(ACC_LENGTH);
    localparam logic [BIT_W-1:0] N_PHASE  = BIT_W'(PHASE_LENGTH);

    logic [2:0]            state_q, state_d;
    logic [DIV_W-1:0]      div_q, div_d;
    logic [BIT_W-1:0]      bit_q, bit_d;
    logic [ACC_LENGTH-1:0] shift_q, shift_d;
    logic                  tgt_q, tgt_d;

    logic spi_clk_d, spi_data_d, freq_cs_d, phaseshift_cs_d, busy_d, done_d;

    // The word always sits at the top of the shift register so the serial
    // bit is shift_q[MSB] regardless of target; a phase word is left-aligned.
    logic [ACC_LENGTH-1:0] w_load;
    logic                  w_div_last;

    assign w_load     = target ? (ACC_LENGTH'(data_in[PHASE_LENGTH-1:0]) << (ACC_LENGTH - PHASE_LENGTH))
                               : data_in;
    assign w_div_last = (div_q == DIV_LAST);

    // State, counters and datapath registers
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tgt_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tgt_q   <= tgt_d;
        end
    end

    // Next-state logic: each non-idle state lasts exactly CLK_DIV cycles
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tgt_d   = tgt_q;
        if (state_q == S_IDLE) begin
            div_d = '0;
            if (start) begin
                state_d = S_SETUP;
                tgt_d   = target;
                bit_d   = target ? N_PHASE : N_FREQ;
                shift_d = w_load;
            end
        end else if (!w_div_last) begin
            div_d = div_q + 1'b1;
        end else begin
            div_d = '0;
            case (state_q)
                S_SETUP: state_d = S_HIGH;
                S_HIGH: begin
                    state_d = S_LOW;
                    bit_d   = bit_q - 1'b1;
                    // Advance data on entry to LOW, but hold the final bit
                    if (bit_q != {{(BIT_W-1){1'b0}}, 1'b1}) begin
                        shift_d = shift_q << 1;
                    end
                end
                S_LOW:   state_d = (bit_q != '0) ? S_HIGH : S_GAP;
                S_GAP:   state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output decode from the next state so every output leaves a flop
    always_comb begin
        spi_clk_d       = 1'b0;
        spi_data_d      = 1'b0;
        freq_cs_d       = 1'b0;
        phaseshift_cs_d = 1'b0;
        busy_d          = (state_d != S_IDLE);
        done_d          = (state_q == S_GAP) && w_div_last;
        if (state_d == S_SETUP || state_d == S_HIGH || state_d == S_LOW) begin
            freq_cs_d       = ~tgt_d;
            phaseshift_cs_d = tgt_d;
            spi_data_d      = shift_d[ACC_LENGTH-1];
            spi_clk_d       = (state_d == S_HIGH);
        end
    end

    // Output registers; reset drops the whole bus immediately
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            spi_clk       <= 1'b0;
            spi_data      <= 1'b0;
            freq_cs       <= 1'b0;
            phaseshift_cs <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            spi_clk       <= spi_clk_d;
            spi_data      <= spi_data_d;
            freq_cs       <= freq_cs_d;
            phaseshift_cs <= phaseshift_cs_d;
            busy          <= busy_d;
            done          <= done_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/dds_spi_master.md
# dds_spi_master

SPI transmitter that loads the DDS core's frequency-tuning word and phase-shift word over the `spi_clk` / `spi_data` / `freq_cs` / `phaseshift_cs` bus. It runs on the system clock, accepts a word plus a target select through a start/busy/done handshake, and serialises the word MSB-first. It raises the selected chip select for the whole transfer and lowers it at the end, which commits the word inside `dds`. It sits between the host/control logic and the `dds` SPI inputs.

## Interface
- `ACC_LENGTH`, default 48: frequency word width; also the `data_in` width.
- `PHASE_LENGTH`, default 16: phase-shift word width. Must satisfy `PHASE_LENGTH <= ACC_LENGTH`.
- `CLK_DIV`, default 5: `sys_clk` cycles per half `spi_clk` period (H). Must be ≥ 1.

Ports:
- `sys_clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a transfer; sampled only while `busy`=0.
- `target`  in  1  0 = frequency word (`freq_cs`), 1 = phase word (`phaseshift_cs`); latched at start.
- `data_in`  in  ACC_LENGTH  word to send; latched at start. For `target`=1 only bits [PHASE_LENGTH-1:0] are sent.
- `spi_clk`  out  1  serial clock; idles low.
- `spi_data`  out  1  serial data; the DDS samples it on the rising edge of `spi_clk`.
- `freq_cs`  out  1  high while a frequency word is being shifted.
- `phaseshift_cs`  out  1  high while a phase word is being shifted.
- `busy`  out  1  high from the cycle after start is accepted until done.
- `done`  out  1  one-cycle pulse when a transfer completes.

## Operation
- N = ACC_LENGTH for `target`=0; N = PHASE_LENGTH for `target`=1.
- On reset, all outputs go to 0. The FSM goes to IDLE and the counters clear.
- **IDLE:** all outputs 0. If `start`=1, the block latches `target` and `data_in` into the shift register (MSB-aligned to bit N-1) and goes to SETUP.
- **SETUP** (H cycles):
  - selected cs = 1, `spi_clk` = 0, `spi_data` = bit N-1.
  - Then go to HIGH.
- **HIGH** (H cycles):
  - `spi_clk` = 1; data held stable.
  - Then go to LOW and decrement the bit counter.
- **LOW** (H cycles):
  - `spi_clk` = 0.
  - At entry, `spi_data` advances to the next lower bit. On the last bit it holds its value.
  - If bits remain, go to HIGH. Otherwise go to GAP.
- **GAP** (H cycles):
  - both cs = 0, `spi_clk` = 0.
  - This guarantees a cs-low interval of at least H before any next transfer.
  - Then `done`=1 for one cycle, `busy`=0, and go to IDLE.
- The unselected cs stays 0 for the whole transfer. Exactly N rising edges of `spi_clk` occur per transfer.
- Counters:
  - half-period divider: `$clog2(CLK_DIV+1)` bits, wraps at H-1.
  - bit counter: `$clog2(ACC_LENGTH+1)` bits, counts N down to 0.
- `start` while `busy`=1 is ignored; no queueing.
- `start` in the same cycle `done`=1: accepted, because `busy` is already 0 in that cycle. The next SETUP follows immediately.
- Reset mid-transfer: outputs drop to 0 asynchronously. The resulting cs fall may commit a partial word in `dds`. This is accepted behaviour; the host re-sends after reset.

## Timing
- Let the start-accept edge be cycle 0.
- `busy` and the selected cs rise in cycle 1, with `spi_data` = MSB.
- Rising edges of `spi_clk` start at cycle 1 + H + 2kH, for k = 0..N-1.
- cs falls at cycle 1 + H + 2NH.
- `done` pulses at cycle 1 + 2H(N+1), and `busy` is 0 in that same cycle.
- Data setup and hold around each rising `spi_clk` edge is H `sys_clk` cycles each.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- **Freq word, CLK_DIV=1:** `data_in`=48'h123456789ABC, `target`=0.
  - Exactly 48 `spi_clk` rising edges; captured bits = 0x123456789ABC MSB-first.
  - `freq_cs` high for 97 cycles; `phaseshift_cs` stays 0.
  - `done` pulses at cycle 99.
- **Phase word, CLK_DIV=3:** `data_in`=48'hFFFF_FFFF_A5C3, `target`=1.
  - 16 rising edges; captured bits = 0xA5C3 (upper bits ignored).
  - `phaseshift_cs` high 99 cycles; `done` at cycle 103.
- **Busy rejection:** pulse `start` with a different word mid-transfer.
  - The transfer in flight is unchanged.
  - No second transfer occurs; exactly one `done`.
- **Back-to-back:** hold `start`=1 with `target` toggled at `done`.
  - The second transfer begins the next cycle on the other cs.
  - Both cs are low for ≥ H cycles between transfers.
- **Reset mid-transfer:** assert `reset` after 10 of 48 bits.
  - All outputs go to 0 immediately, with no `done`.
  - After release, a new transfer completes correctly with 48 edges.
- **Loopback:** drive the `dds` SPI inputs from this block.
  - After a freq write of 1, `waveform_out` begins changing once `freq_cs` falls.
